// File: rtl/ann_stream_loader.sv
// Streams image and weight words into the classifier load port,
// runs one inference per frame and scores it against the label.
module ann_stream_loader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int IMG_BYTES = 784,
  parameter int W_BYTES   = 15600,
  parameter int CLASS_W   = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [CLASS_W-1:0] s_label,
  input  logic               reload_weights,
  input  logic               clr_stats,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [DATA_W-1:0]  mem_wr_data,
  output logic               dut_start,
  input  logic               dut_done,
  input  logic [CLASS_W-1:0] dut_class,
  output logic               res_valid,
  output logic [CLASS_W-1:0] res_class,
  output logic [CLASS_W-1:0] res_label,
  output logic               res_pass,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic [CNT_W-1:0]   total_count,
  output logic               timeout_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD_IMG, LOAD_W, START, WAIT, REPORT
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_BYTES - 1);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(W_BYTES - 1);
  localparam logic [ADDR_W-1:0] W_BASE   = ADDR_W'(IMG_BYTES);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [WD_W-1:0]     wd;
  logic                weights_valid;
  logic [CLASS_W-1:0]  label_q;
  logic                hs;
  logic                skip_w;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign s_ready = ~rst & ((state == IDLE) |
                           (state == LOAD_IMG) |
                           (state == LOAD_W));
  assign busy    = ~rst & (state != IDLE);
  assign hs      = s_valid & s_ready;
  // A reload pulse on the last image word must still force a weight pass.
  assign skip_w  = weights_valid & ~reload_weights;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      wd            <= '0;
      weights_valid <= 1'b0;
      label_q       <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      dut_start     <= 1'b0;
      res_valid     <= 1'b0;
      res_class     <= '0;
      res_label     <= '0;
      res_pass      <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      total_count   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      dut_start <= 1'b0;
      res_valid <= 1'b0;
      unique case (state)
        IDLE: if (hs) begin
          label_q     <= s_label;
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= '0;
          mem_wr_data <= s_data;
          if (IMG_BYTES == 1) begin
            idx   <= '0;
            state <= skip_w ? START : LOAD_W;
          end else begin
            idx   <= ADDR_W'(1);
            state <= LOAD_IMG;
          end
        end
        LOAD_IMG: if (hs) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= idx;
          mem_wr_data <= s_data;
          if (idx == IMG_LAST) begin
            idx   <= '0;
            state <= skip_w ? START : LOAD_W;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        LOAD_W: if (hs) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= W_BASE + idx;
          mem_wr_data <= s_data;
          if (idx == W_LAST) begin
            idx           <= '0;
            weights_valid <= 1'b1;
            state         <= START;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        START: begin
          wd        <= '0;
          dut_start <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          // done is stale during the start pulse; only look after it.
          if (!dut_start && dut_done) begin
            res_class <= dut_class;
            res_label <= label_q;
            res_pass  <= (dut_class == label_q);
            res_valid <= 1'b1;
            state     <= REPORT;
          end else if (wd == WD_LAST) begin
            timeout_err <= 1'b1;
            res_class   <= '1;
            res_label   <= label_q;
            res_pass    <= 1'b0;
            res_valid   <= 1'b1;
            state       <= REPORT;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        REPORT: begin
          total_count <= sat_inc(total_count);
          if (res_pass) pass_count <= sat_inc(pass_count);
          else          fail_count <= sat_inc(fail_count);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (reload_weights) weights_valid <= 1'b0;
      if (clr_stats) begin
        pass_count  <= '0;
        fail_count  <= '0;
        total_count <= '0;
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ann_stream_loader.sv
// Directed bench for ann_stream_loader with a small image/weight
// geometry and a short watchdog.
module tb_ann_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic [3:0]  s_label = '0;
  logic        reload_weights = 1'b0;
  logic        clr_stats = 1'b0;
  logic        mem_wr_en;
  logic [13:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        dut_start;
  logic        dut_done = 1'b0;
  logic [3:0]  dut_class = '0;
  logic        res_valid;
  logic [3:0]  res_class;
  logic [3:0]  res_label;
  logic        res_pass;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic [15:0] total_count;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [13:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int starts = 0;
  int overlap = 0;
  int wcyc = 0;
  bit wact = 1'b0;

  ann_stream_loader #(
    .ADDR_W(14), .DATA_W(8), .IMG_BYTES(4), .W_BYTES(3),
    .CLASS_W(4), .CNT_W(16), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_label(s_label),
    .reload_weights(reload_weights), .clr_stats(clr_stats),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .dut_start(dut_start), .dut_done(dut_done),
    .dut_class(dut_class),
    .res_valid(res_valid), .res_class(res_class),
    .res_label(res_label), .res_pass(res_pass),
    .pass_count(pass_count), .fail_count(fail_count),
    .total_count(total_count),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa_q.push_back(mem_wr_addr);
      wd_q.push_back(mem_wr_data);
    end
    if (dut_start) starts++;
    if (dut_start && mem_wr_en) overlap++;
    if (dut_start) begin
      wact = 1'b1;
      wcyc = 1;
    end else if (res_valid) begin
      wact = 1'b0;
    end else if (wact) begin
      wcyc++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base,
                            input logic [3:0] lab, input bit gap);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < n && guard < 200) begin
      s_valid = !(gap && (guard % 2 == 1));
      s_data  = base + 8'(i);
      s_label = lab;
      hs = s_valid && s_ready;
      tick();
      if (hs) i++;
      guard++;
    end
    s_valid = 1'b0;
    if (i != n) chk("send_words", 32'(i), 32'(n));
  endtask

  task automatic wait_start();
    int k = 0;
    while (!dut_start && k < 20) begin
      tick();
      k++;
    end
    if (!dut_start) chk("dut_start_seen", 32'(dut_start), 1);
  endtask

  task automatic wait_rv(input int lim);
    int k = 0;
    while (!res_valid && k < lim) begin
      tick();
      k++;
    end
    if (!res_valid) chk("res_valid_seen", 32'(res_valid), 1);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    starts = 0;
    overlap = 0;
  endtask

  task automatic chk_writes(input string tag, input int n,
                            input int a0, input logic [7:0] d0);
    chk({tag, "_count"}, 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(wa_q[i]), 32'(a0 + i));
      chk({tag, "_data"}, 32'(wd_q[i]), 32'(d0 + 8'(i)));
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_start", 32'(dut_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_total", 32'(total_count), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(s_ready), 1);

    // Frame 1: image + weights, correct class.
    clear_log();
    send_frame(7, 8'h10, 4'd3, 1'b0);
    wait_start();
    repeat (5) tick();
    dut_done = 1'b1;
    dut_class = 4'd3;
    wait_rv(20);
    chk("f1_pass", 32'(res_pass), 1);
    chk("f1_class", 32'(res_class), 3);
    chk("f1_label", 32'(res_label), 3);
    dut_done = 1'b0;
    tick();
    chk_writes("f1_wr", 7, 0, 8'h10);
    chk("f1_starts", 32'(starts), 1);
    chk("f1_overlap", 32'(overlap), 0);
    chk("f1_pass_cnt", 32'(pass_count), 1);
    chk("f1_total", 32'(total_count), 1);
    chk("f1_busy", 32'(busy), 0);

    // Frame 2: weights cached, wrong class.
    clear_log();
    send_frame(4, 8'h20, 4'd5, 1'b0);
    wait_start();
    repeat (2) tick();
    dut_done = 1'b1;
    dut_class = 4'd2;
    wait_rv(20);
    chk("f2_pass", 32'(res_pass), 0);
    chk("f2_class", 32'(res_class), 2);
    chk("f2_label", 32'(res_label), 5);
    dut_done = 1'b0;
    tick();
    chk_writes("f2_wr", 4, 0, 8'h20);
    chk("f2_fail_cnt", 32'(fail_count), 1);
    chk("f2_total", 32'(total_count), 2);

    // Frame 3: reload forces weights to be rewritten.
    reload_weights = 1'b1;
    tick();
    reload_weights = 1'b0;
    clear_log();
    send_frame(7, 8'h30, 4'd1, 1'b0);
    wait_start();
    tick();
    dut_done = 1'b1;
    dut_class = 4'd1;
    wait_rv(20);
    dut_done = 1'b0;
    tick();
    chk_writes("f3_wr", 7, 0, 8'h30);
    chk("f3_pass_cnt", 32'(pass_count), 2);
    chk("f3_total", 32'(total_count), 3);

    // Frame 4: done never comes, watchdog fires.
    clear_log();
    send_frame(4, 8'h40, 4'd0, 1'b0);
    wait_start();
    wait_rv(200);
    chk("f4_wait_cycles", 32'(wcyc), 50);
    chk("f4_timeout", 32'(timeout_err), 1);
    chk("f4_class", 32'(res_class), 32'hF);
    chk("f4_pass", 32'(res_pass), 0);
    tick();
    chk("f4_fail_cnt", 32'(fail_count), 2);
    chk("f4_total", 32'(total_count), 4);

    // Frame 5: bubbly stream, done already high at start.
    dut_done = 1'b1;
    dut_class = 4'd7;
    clear_log();
    send_frame(4, 8'h50, 4'd7, 1'b1);
    wait_start();
    wait_rv(20);
    chk("f5_wait_cycles", 32'(wcyc), 2);
    chk("f5_pass", 32'(res_pass), 1);
    dut_done = 1'b0;
    tick();
    chk_writes("f5_wr", 4, 0, 8'h50);
    chk("f5_pass_cnt", 32'(pass_count), 3);
    chk("f5_timeout_sticky", 32'(timeout_err), 1);

    // Frame 6: reset during weight load, then clear on report.
    reload_weights = 1'b1;
    tick();
    reload_weights = 1'b0;
    send_frame(5, 8'h60, 4'd2, 1'b0);
    chk("f6_busy_loadw", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("f6_rst_busy", 32'(busy), 0);
    chk("f6_rst_total", 32'(total_count), 0);
    chk("f6_rst_timeout", 32'(timeout_err), 0);
    chk("f6_rst_class", 32'(res_class), 0);
    rst = 1'b0;
    tick();
    clear_log();
    send_frame(7, 8'h70, 4'd2, 1'b0);
    wait_start();
    repeat (2) tick();
    dut_done = 1'b1;
    dut_class = 4'd2;
    wait_rv(20);
    clr_stats = 1'b1;
    dut_done = 1'b0;
    tick();
    clr_stats = 1'b0;
    chk_writes("f6_wr", 7, 0, 8'h70);
    chk("f6_pass_held", 32'(res_pass), 1);
    chk("f6_pass_cnt", 32'(pass_count), 0);
    chk("f6_fail_cnt", 32'(fail_count), 0);
    chk("f6_total", 32'(total_count), 0);
    chk("f6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
